// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and arithmetic helpers for the ternary convolution engine.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package cnn_pkg;

    // 2-bit ternary weight codes; 2'b00 and 2'b10 both mean zero.
    localparam logic [1:0] W_POS = 2'b01;
    localparam logic [1:0] W_NEG = 2'b11;

    localparam int NUM_TAPS = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_t;

    // Nine taps of at most 2^data_w-1 each need 4 growth bits plus a sign bit.
    function automatic int calc_acc_w(input int data_w);
        return data_w + 5;
    endfunction

    // ReLU, then arithmetic shift, then clamp to the unsigned output range.
    function automatic logic [31:0] relu_sat(input logic signed [31:0] sum,
                                             input int                 shift,
                                             input int                 out_w);
        logic [31:0] shifted;
        logic [31:0] max_val;
        max_val = (32'd1 << out_w) - 32'd1;
        if (sum < 0) begin
            return '0;
        end
        shifted = sum >>> shift;
        return (shifted > max_val) ? max_val : shifted;
    endfunction

endpackage

// File: rtl/ocm_ternary_conv3x3_if.sv
// ocm_ternary_conv3x3_if: image-OCM read port plus result-OCM write port.
// Latency: rd_data follows rd_addr by exactly one cycle; writes complete in their strobe cycle.
// Backpressure: none; neither OCM port can stall the engine.
// master = convolution engine, slave = memory side.
interface ocm_ternary_conv3x3_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8
);
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_chip;
    logic              rd_clken;
    logic [DATA_W-1:0] rd_data;

    logic [ADDR_W-1:0] wr_addr;
    logic              wr_chip;
    logic              wr_clken;
    logic              wr_write;
    logic [OUT_W-1:0]  wr_data;

    modport master (
        output rd_addr, rd_chip, rd_clken,
        input  rd_data,
        output wr_addr, wr_chip, wr_clken, wr_write, wr_data
    );

    modport slave (
        input  rd_addr, rd_chip, rd_clken,
        output rd_data,
        input  wr_addr, wr_chip, wr_clken, wr_write, wr_data
    );
endinterface

// File: rtl/line_buffer.sv
// line_buffer: DEPTH-entry shift register; dout is the sample pushed DEPTH enables ago.
// Latency: DEPTH enabled cycles from din to dout; dout is a plain register output.
// Backpressure: none; shifts only when en is high.
// Ports: clk, reset (async high), en, din[WIDTH], dout[WIDTH].
module line_buffer #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else if (en) begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/ocm_ternary_conv3x3.sv
// ocm_ternary_conv3x3: streams an image from OCM, 3x3 ternary MAC + ReLU/shift/saturate, writes results.
// Latency: pixel k read at start+1+k, its window result written at start+3+k; done at start+3+W*H.
// Backpressure: none; one read per cycle with no stalls, writes are fire-and-forget.
// Ports: clk, reset (async high), start, weights[18] (w11 at [1:0] .. w33 at [17:16]),
//        busy, done (1-cycle pulse), out_count[16], ocm (master: rd_* image port, wr_* result port).
module ocm_ternary_conv3x3
    import cnn_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 17,
    parameter int SHIFT  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [17:0] weights,
    output logic        busy,
    output logic        done,
    output logic [15:0] out_count,
    ocm_ternary_conv3x3_if.master ocm
);

    localparam int ACC_W = calc_acc_w(DATA_W);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    conv_state_t state;
    conv_state_t state_nxt;

    logic [ADDR_W-1:0] rd_cnt;
    logic              drain_cnt;   // which of the two drain cycles we are in
    logic              rd_active;
    logic              frame_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rd_active   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        frame_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    frame_start = 1'b1;
                    state_nxt   = ST_READ;
                end
            end
            ST_READ: begin
                rd_active = 1'b1;
                busy      = 1'b1;
                if (rd_cnt == LAST_ADDR) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // first cycle: last pixel arrives; second cycle: its write goes out
                busy = 1'b1;
                if (drain_cnt) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read address counter returns to 0 at the end of the frame so the bus idles at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt    <= '0;
            drain_cnt <= 1'b0;
        end else begin
            if (frame_start) begin
                rd_cnt <= '0;
            end else if (state == ST_READ) begin
                rd_cnt <= (rd_cnt == LAST_ADDR) ? '0 : rd_cnt + ADDR_W'(1);
            end
            if (state == ST_DRAIN) begin
                drain_cnt <= ~drain_cnt;
            end
        end
    end

    // ---------------------------------------------------------------
    // Pixel arrival tracking and window formation
    // ---------------------------------------------------------------
    logic [17:0]       w_q;
    logic              pix_vld;      // rd_data holds a fresh pixel this cycle
    logic [COL_W-1:0]  pix_col;      // position of the pixel currently on rd_data
    logic [ROW_W-1:0]  pix_row;
    logic              win_vld;

    logic [DATA_W-1:0] lb1_out;      // row r-1, column c
    logic [DATA_W-1:0] lb2_out;      // row r-2, column c

    // [0] = column c-2, [1] = column c-1; column c comes straight from the line buffers / rd_data.
    logic [1:0][DATA_W-1:0] win_top;
    logic [1:0][DATA_W-1:0] win_mid;
    logic [1:0][DATA_W-1:0] win_bot;

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
        .clk   (clk),
        .reset (reset),
        .en    (pix_vld),
        .din   (ocm.rd_data),
        .dout  (lb1_out)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb2 (
        .clk   (clk),
        .reset (reset),
        .en    (pix_vld),
        .din   (lb1_out),
        .dout  (lb2_out)
    );

    // Windows that would straddle a row wrap have c<2 and are suppressed here.
    assign win_vld = pix_vld && (pix_row >= ROW_W'(2)) && (pix_col >= COL_W'(2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q     <= '0;
            pix_vld <= 1'b0;
            pix_col <= '0;
            pix_row <= '0;
            win_top <= '0;
            win_mid <= '0;
            win_bot <= '0;
        end else begin
            pix_vld <= rd_active;
            if (frame_start) begin
                w_q     <= weights;
                pix_col <= '0;
                pix_row <= '0;
            end else if (pix_vld) begin
                if (pix_col == LAST_COL) begin
                    pix_col <= '0;
                    pix_row <= pix_row + ROW_W'(1);
                end else begin
                    pix_col <= pix_col + COL_W'(1);
                end
            end
            if (pix_vld) begin
                win_top <= {lb2_out,     win_top[1]};
                win_mid <= {lb1_out,     win_mid[1]};
                win_bot <= {ocm.rd_data, win_bot[1]};
            end
        end
    end

    // ---------------------------------------------------------------
    // Ternary MAC and post-processing (combinational, registered at the write stage)
    // ---------------------------------------------------------------
    logic [DATA_W-1:0]       taps [NUM_TAPS];
    logic signed [ACC_W-1:0] sum;
    logic [OUT_W-1:0]        result;

    // Tap order matches the weight packing: row-major, w11 first.
    always_comb begin
        taps[0] = win_top[0];
        taps[1] = win_top[1];
        taps[2] = lb2_out;
        taps[3] = win_mid[0];
        taps[4] = win_mid[1];
        taps[5] = lb1_out;
        taps[6] = win_bot[0];
        taps[7] = win_bot[1];
        taps[8] = ocm.rd_data;
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            case (w_q[2*i +: 2])
                W_POS:   sum = sum + $signed(ACC_W'(taps[i]));
                W_NEG:   sum = sum - $signed(ACC_W'(taps[i]));
                default: sum = sum;
            endcase
        end
    end

    assign result = OUT_W'(relu_sat(32'(sum), SHIFT, OUT_W));

    // ---------------------------------------------------------------
    // Write stage
    // ---------------------------------------------------------------
    logic              wr_vld;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [OUT_W-1:0]  wr_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_vld    <= 1'b0;
            wr_cnt    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            out_count <= '0;
        end else begin
            wr_vld <= win_vld;
            if (frame_start) begin
                wr_cnt    <= '0;
                out_count <= '0;
            end else begin
                if (win_vld) begin
                    wr_addr_q <= wr_cnt;
                    wr_data_q <= result;
                    wr_cnt    <= wr_cnt + ADDR_W'(1);
                end
                if (wr_vld) begin
                    out_count <= out_count + 16'd1;
                end
            end
        end
    end

    assign ocm.rd_addr  = rd_cnt;
    assign ocm.rd_chip  = rd_active;
    assign ocm.rd_clken = rd_active;
    assign ocm.wr_addr  = wr_addr_q;
    assign ocm.wr_data  = wr_data_q;
    assign ocm.wr_chip  = wr_vld;
    assign ocm.wr_clken = wr_vld;
    assign ocm.wr_write = wr_vld;

endmodule

// File: tb/tb_ocm_ternary_conv3x3.sv
// tb_ocm_ternary_conv3x3: directed frames on a 4x4 image against hand-computed results.
// Latency: checks start-to-write and start-to-done cycle offsets for every frame.
// Backpressure: none; OCM models answer every access.
module tb_ocm_ternary_conv3x3;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        start   = 1'b0;
    logic [17:0] weights = '0;

    logic        busy0, done0, busy4, done4;
    logic [15:0] cnt0, cnt4;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    logic [7:0] img [16];

    // write logs (dut0: full detail, dut4: data only)
    int wa0 [8];
    int wd0 [8];
    int wc0 [8];
    int ws0 [8];
    int nw0 = 0;
    int wd4 [8];
    int nw4 = 0;

    ocm_ternary_conv3x3_if #(.ADDR_W(17), .DATA_W(8), .OUT_W(8)) bus0 ();
    ocm_ternary_conv3x3_if #(.ADDR_W(17), .DATA_W(8), .OUT_W(8)) bus4 ();

    ocm_ternary_conv3x3 #(
        .IMG_W(4), .IMG_H(4), .DATA_W(8), .OUT_W(8), .ADDR_W(17), .SHIFT(0)
    ) dut0 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .weights   (weights),
        .busy      (busy0),
        .done      (done0),
        .out_count (cnt0),
        .ocm       (bus0)
    );

    ocm_ternary_conv3x3 #(
        .IMG_W(4), .IMG_H(4), .DATA_W(8), .OUT_W(8), .ADDR_W(17), .SHIFT(4)
    ) dut4 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .weights   (weights),
        .busy      (busy4),
        .done      (done4),
        .out_count (cnt4),
        .ocm       (bus4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // image OCMs: one-cycle read latency
    always @(posedge clk) begin
        if (bus0.rd_chip && bus0.rd_clken) bus0.rd_data <= img[bus0.rd_addr[3:0]];
        if (bus4.rd_chip && bus4.rd_clken) bus4.rd_data <= img[bus4.rd_addr[3:0]];
    end

    // result OCM monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (bus0.wr_chip || bus0.wr_clken || bus0.wr_write) begin
            if (nw0 < 8) begin
                wa0[nw0] = int'(bus0.wr_addr);
                wd0[nw0] = int'(bus0.wr_data);
                wc0[nw0] = cyc;
                ws0[nw0] = (bus0.wr_chip && bus0.wr_clken && bus0.wr_write) ? 1 : 0;
            end
            nw0 = nw0 + 1;
        end
        if (bus4.wr_write) begin
            if (nw4 < 8) wd4[nw4] = int'(bus4.wr_data);
            nw4 = nw4 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) img[i] = 8'(i);
    endtask

    task automatic load_const(input logic [7:0] v);
        for (int i = 0; i < 16; i++) img[i] = v;
    endtask

    // One 4x4 frame: start at cycle S, expect writes at S+13,14,17,18 and done at S+19.
    task automatic run_frame(input string tag, input logic [17:0] w, input bit disturb,
                             input int e0, input int e1, input int e2, input int e3);
        int exp_d [4];
        int exp_t [4];
        int s_cyc;
        int done_at;
        int busy_first;
        int busy_last;
        exp_d = '{e0, e1, e2, e3};
        exp_t = '{13, 14, 17, 18};
        @(negedge clk);
        nw0 = 0;
        nw4 = 0;
        weights = w;
        start   = 1'b1;
        s_cyc   = cyc;
        done_at = -1;
        busy_first = -1;
        busy_last  = -1;
        for (int n = 1; n <= 40 && done_at < 0; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                start   = 1'b0;
                weights = ~w;
            end
            if (disturb && n == 6) begin
                start   = 1'b1;
                weights = 18'h15555;
            end
            if (disturb && n == 7) start = 1'b0;
            if (busy0) begin
                if (busy_first < 0) busy_first = n;
                busy_last = n;
            end
            if (done0) done_at = n;
        end
        chk($sformatf("%s done_cycle", tag), done_at, 19);
        chk($sformatf("%s busy_first", tag), busy_first, 1);
        chk($sformatf("%s busy_last", tag), busy_last, 18);
        chk($sformatf("%s n_writes", tag), nw0, 4);
        chk($sformatf("%s out_count", tag), cnt0, 4);
        for (int i = 0; i < 4 && i < nw0; i++) begin
            chk($sformatf("%s addr%0d", tag, i), wa0[i], i);
            chk($sformatf("%s data%0d", tag, i), wd0[i], exp_d[i]);
            chk($sformatf("%s wcyc%0d", tag, i), wc0[i] - s_cyc, exp_t[i]);
            chk($sformatf("%s strobes%0d", tag, i), ws0[i], 1);
        end
        @(posedge clk);
        #1;
        chk($sformatf("%s done_pulse_end", tag), {busy0, done0}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1);
    end

    initial begin
        load_ramp();
        repeat (3) @(negedge clk);
        chk("rst flags_strobes_count",
            {busy0, done0, bus0.rd_chip, bus0.rd_clken, bus0.wr_chip, bus0.wr_clken,
             bus0.wr_write, cnt0}, 0);
        chk("rst rd_addr", bus0.rd_addr, 0);
        chk("rst wr_addr", bus0.wr_addr, 0);
        chk("rst wr_data", bus0.wr_data, 0);
        reset = 1'b0;

        // only w22=+1: results are the window centres 5,6,9,10
        run_frame("w22", 18'h00100, 1'b0, 5, 6, 9, 10);
        // code 2'b10 everywhere else must act as zero
        run_frame("code10", 18'h2A9AA, 1'b0, 5, 6, 9, 10);
        // w33=+1, w11=-1: x(r,c)-x(r-2,c-2) = 10 for every window
        run_frame("diag", 18'h10003, 1'b0, 10, 10, 10, 10);
        // w13=+1, w21=+1 latched; mid-frame start and weight change ignored
        run_frame("latched", 18'h00050, 1'b1, 6, 8, 14, 16);

        // saturation: 9*255 = 2295 clamps to 255; SHIFT=4 instance gives 143
        load_const(8'd255);
        run_frame("sat", 18'h15555, 1'b0, 255, 255, 255, 255);
        chk("shift4 n_writes", nw4, 4);
        for (int i = 0; i < 4 && i < nw4; i++) begin
            chk($sformatf("shift4 data%0d", i), wd4[i], 143);
        end

        // all -1 on a ramp: every sum negative, ReLU gives 0
        load_ramp();
        run_frame("relu", 18'h3FFFF, 1'b0, 0, 0, 0, 0);

        // reset while pixel 7 is being read
        begin
            bit found;
            found = 1'b0;
            @(negedge clk);
            weights = 18'h00100;
            start   = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int n = 0; n < 40; n++) begin
                if (bus0.rd_chip && bus0.rd_addr == 17'd7) begin
                    found = 1'b1;
                    break;
                end
                @(posedge clk);
                #1;
            end
            chk("midrst reached_pixel7", found, 1);
            chk("midrst busy_before", busy0, 1);
            reset = 1'b1;
            #1;
            chk("midrst busy", busy0, 0);
            chk("midrst rd_addr", bus0.rd_addr, 0);
            chk("midrst rd_strobes", {bus0.rd_chip, bus0.rd_clken}, 0);
            chk("midrst wr_strobes", {bus0.wr_chip, bus0.wr_clken, bus0.wr_write}, 0);
            chk("midrst out_count", cnt0, 0);
            repeat (2) @(negedge clk);
            reset = 1'b0;
        end
        run_frame("after_rst", 18'h00100, 1'b0, 5, 6, 9, 10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/ocm_ternary_conv3x3.md
# ocm_ternary_conv3x3

Streaming 3x3 ternary-weight convolution engine between the image on-chip RAM (read port) and the result on-chip RAM (write port). It replaces the fixed readOCM → adder → writeAuxDataOCM chain with one parametrised block. On `start` it reads a full image in raster order and builds 3x3 windows with two line buffers. For each window it computes a signed ternary MAC, then applies ReLU, shift and saturation, and writes one result per valid window.

## Interface
Parameters:
- IMG_W, 28: image width in pixels (≥3)
- IMG_H, 28: image height in pixels (≥3)
- DATA_W, 8: input pixel width (unsigned)
- OUT_W, 8: output result width (unsigned)
- ADDR_W, 17: OCM address width, both ports
- SHIFT, 0: arithmetic right shift applied to the sum before saturation

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  frame start request, sampled only in IDLE
- weights  in  18  nine 2-bit codes, w11 at [1:0] … w33 at [17:16]; 01=+1, 11=−1, 00/10=0
- busy  out  1  high from first read cycle until last write cycle
- done  out  1  one-cycle pulse after last write
- rd_addr  out  ADDR_W  image OCM address
- rd_chip, rd_clken  out  1  image OCM chipselect/clken, high while reading
- rd_data  in  DATA_W  image OCM readdata, fixed 1-cycle latency
- wr_addr  out  ADDR_W  result OCM address
- wr_chip, wr_clken, wr_write  out  1  result OCM strobes, high together for one cycle per result
- wr_data  out  OUT_W  result value
- out_count  out  16  results written in current/last frame

## Operation
- States: IDLE → READ (issue IMG_W·IMG_H addresses) → DRAIN (finish pipeline) → DONE (1 cycle) → IDLE.
- IDLE: when `start` is high, latch `weights`, clear counters and `out_count`, go to READ. `start` is ignored outside IDLE.
- READ: `rd_addr` increments from 0 to IMG_W·IMG_H−1, one per cycle, with no stalls.
- Arriving pixel k = r·IMG_W+c shifts into the window. The line buffers hold rows r−1 and r−2.
- A window is valid iff r≥2 and c≥2. Valid convolution only, no padding, so the output is (IMG_W−2)×(IMG_H−2). Windows are not formed across row wrap (c<2 is suppressed).
- Sum = Σ w_ij·x_ij as signed, ACC_W = DATA_W+5. Then result = 0 if sum<0; else min(sum>>>SHIFT, 2^OUT_W−1).
- `wr_addr` = (r−2)·(IMG_W−2)+(c−2), sequential from 0. `out_count` increments on every write.
- Reset, including mid-frame: return to IDLE. All outputs go to 0, counters and the window clear, and any partial frame is abandoned.

## Timing
- `start` sampled at cycle S. `rd_addr=0` with rd strobes is driven in S+1.
- Pixel k is read in S+1+k, its data arrives in S+2+k, and its write (if valid) is in S+3+k.
- Last write is in S+2+IMG_W·IMG_H. `busy` is high S+1 … S+2+IMG_W·IMG_H. `done` is high in S+3+IMG_W·IMG_H. The next `start` is accepted from S+4+IMG_W·IMG_H (IDLE).
- Reset values: busy=0, done=0, all rd_*/wr_* strobes and buses=0, out_count=0.
- Weights changing during a frame have no effect; only the value latched at start is used.

## Structure
- Shared package `cnn_pkg`:
  - weight code constants (W_POS=2'b01, W_NEG=2'b11)
  - state enum
  - function for ACC_W
  - saturate/ReLU function
- Sub-module `line_buffer` (depth IMG_W, width DATA_W, 1-cycle shift register/RAM), instantiated twice.
- Top holds the FSM, address counters, window registers and the MAC/post-processing pipeline stage.

## Test plan
- IMG_W=IMG_H=4, pixels 0..15, only w22=+1 → writes 5,6,9,10 at addr 0..3; done at S+19; out_count=4.
- All weights +1, all pixels 255, SHIFT=0 → sum 2295 saturates, every result 255.
- All weights −1, nonzero image → every result 0 (ReLU).
- All +1, pixels 255, SHIFT=4 → 2295>>>4=143 written everywhere.
- `start` pulsed mid-frame, weights changed mid-frame → no restart, results follow the latched weights.
- Reset asserted at pixel 7 → all outputs 0 immediately. A new start then produces a full correct frame from addr 0.
